process_delay_line_array: RTL and testbench

//  Clocked, synthesizable successor to the process delay model: CHANNELS independent delay

---
 rtl/process_delay_line_array.sv | 191 +++++++++++++++++++
 tb/tb_process_delay_line_array.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/process_delay_line_array.sv
// process_delay_line_array
//   CHANNELS independent clocked delay lines with runtime-programmable delay. Every input edge
//   is stored as a {timestamp, level} entry in a per-channel edge queue, so several edges can
//   be in flight at once (transport delay). An edge sampled at clock edge k reappears on
//   wire_out at clock edge k+D.
//
//   Optional build macro: PDM_INERTIAL_EN -- inertial delay. An edge arriving while the queue
//   still holds an entry cancels that entry, so pulses narrower than D are swallowed.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous reset, active-low
//   cfg_we     delay write strobe
//   cfg_ch     channel addressed by cfg_we (out-of-range writes ignored)
//   cfg_delay  new delay in cycles (0 -> 1, above MAX_DELAY -> MAX_DELAY)
//   wire_in    per-channel input levels
//   wire_out   per-channel delayed levels
//   busy       per-channel edge queue non-empty
//   overflow   per-channel sticky flag, an edge was dropped because the queue was full
module process_delay_line_array #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned MAX_DELAY     = 64,
  parameter int unsigned DEFAULT_DELAY = 10,
  parameter int unsigned EDGE_DEPTH    = 4,
  localparam int unsigned DW           = $clog2(MAX_DELAY + 1),
  localparam int unsigned TW           = DW + 1,
  localparam int unsigned CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [DW-1:0]       cfg_delay,
  input  logic [CHANNELS-1:0] wire_in,
  output logic [CHANNELS-1:0] wire_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overflow
);

  localparam int unsigned NW = $clog2(EDGE_DEPTH + 1);

  // Free-running timestamp; equality compares are safe because no entry outlives MAX_DELAY.
  logic [TW-1:0]         now_q, now_d;

  // last_q is the input sample register: it holds the most recently sampled level, so a
  // difference against the level being sampled now is an edge at this clock.
  logic [CHANNELS-1:0]   last_q, last_d;
  logic [CHANNELS-1:0]   out_q, out_d;
  logic [CHANNELS-1:0]   busy_q, busy_d;
  logic [CHANNELS-1:0]   ovf_q, ovf_d;
  logic [CHANNELS-1:0]   pend_v_q, pend_v_d;

  logic [DW-1:0]         delay_q [CHANNELS];
  logic [DW-1:0]         delay_d [CHANNELS];
  logic [DW-1:0]         pend_q  [CHANNELS];
  logic [DW-1:0]         pend_d  [CHANNELS];

  // Edge queue, entry 0 is the head. Timestamps are monotonic within a channel because the
  // delay only changes while the queue is empty, so only the head ever needs comparing.
  logic [TW-1:0]         ts_q    [CHANNELS][EDGE_DEPTH];
  logic [TW-1:0]         ts_d    [CHANNELS][EDGE_DEPTH];
  logic [EDGE_DEPTH-1:0] lvl_q   [CHANNELS];
  logic [EDGE_DEPTH-1:0] lvl_d   [CHANNELS];
  logic [NW-1:0]         cnt_q   [CHANNELS];
  logic [NW-1:0]         cnt_d   [CHANNELS];

  logic [DW-1:0]         cfg_clamped;
  logic                  cfg_valid;
  logic [NW-1:0]         cnt_tmp;

  always_comb begin
    if (cfg_delay == '0) begin
      cfg_clamped = DW'(1);
    end else if (32'(cfg_delay) > MAX_DELAY) begin
      cfg_clamped = DW'(MAX_DELAY);
    end else begin
      cfg_clamped = cfg_delay;
    end
  end

  assign cfg_valid = cfg_we && (32'(cfg_ch) < CHANNELS);

  always_comb begin
    now_d    = now_q + TW'(1);
    last_d   = last_q;
    out_d    = out_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    pend_v_d = pend_v_q;
    delay_d  = delay_q;
    pend_d   = pend_q;
    ts_d     = ts_q;
    lvl_d    = lvl_q;
    cnt_d    = cnt_q;
    cnt_tmp  = '0;

    for (int c = 0; c < CHANNELS; c++) begin
      cnt_tmp = cnt_q[c];

      // Pop first so a full queue can still accept an edge in the cycle its head leaves.
      if ((cnt_q[c] != '0) && (ts_q[c][0] == now_q)) begin
        out_d[c] = lvl_q[c][0];
        for (int e = 0; e < EDGE_DEPTH - 1; e++) begin
          ts_d[c][e]  = ts_q[c][e+1];
          lvl_d[c][e] = lvl_q[c][e+1];
        end
        cnt_tmp = cnt_q[c] - NW'(1);
      end

      if (wire_in[c] != last_q[c]) begin
        last_d[c] = wire_in[c];
`ifdef PDM_INERTIAL_EN
        // A pending entry means the pulse is narrower than D: cancel it instead of queueing.
        if (cnt_tmp != '0) begin
          cnt_tmp = cnt_tmp - NW'(1);
        end else begin
          ts_d[c][0]  = now_q + TW'(delay_q[c]);
          lvl_d[c][0] = wire_in[c];
          cnt_tmp     = NW'(1);
        end
`else
        if (cnt_tmp == NW'(EDGE_DEPTH)) begin
          ovf_d[c] = 1'b1;
        end else begin
          for (int e = 0; e < EDGE_DEPTH; e++) begin
            if (NW'(e) == cnt_tmp) begin
              ts_d[c][e]  = now_q + TW'(delay_q[c]);
              lvl_d[c][e] = wire_in[c];
            end
          end
          cnt_tmp = cnt_tmp + NW'(1);
        end
`endif
      end

      cnt_d[c]  = cnt_tmp;
      busy_d[c] = (cnt_tmp != '0);

      // Delay changes are deferred while edges are in flight so their order is kept.
      if (cfg_valid && (cfg_ch == CW'(c))) begin
        if (cnt_q[c] != '0) begin
          pend_v_d[c] = 1'b1;
          pend_d[c]   = cfg_clamped;
        end else begin
          delay_d[c]  = cfg_clamped;
          pend_v_d[c] = 1'b0;
        end
      end else if ((cnt_q[c] == '0) && pend_v_q[c]) begin
        delay_d[c]  = pend_q[c];
        pend_v_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now_q    <= '0;
      last_q   <= '0;
      out_q    <= '0;
      busy_q   <= '0;
      ovf_q    <= '0;
      pend_v_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        delay_q[c] <= DW'(DEFAULT_DELAY);
        pend_q[c]  <= '0;
        lvl_q[c]   <= '0;
        cnt_q[c]   <= '0;
        for (int e = 0; e < EDGE_DEPTH; e++) begin
          ts_q[c][e] <= '0;
        end
      end
    end else begin
      now_q    <= now_d;
      last_q   <= last_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      pend_v_q <= pend_v_d;
      delay_q  <= delay_d;
      pend_q   <= pend_d;
      ts_q     <= ts_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wire_out = out_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_process_delay_line_array.sv
// Testbench for process_delay_line_array (default parameters, either build of
// PDM_INERTIAL_EN). Directed scenarios check constants; all cycles also feed a reference
// model based on absolute cycle numbers and per-channel event queues.
module tb_process_delay_line_array;

  localparam int CH    = 2;
  localparam int MAXD  = 64;
  localparam int DEFD  = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [6:0] cfg_delay = '0;
  logic [1:0] wire_in = '0;
  logic [1:0] wire_out, busy, overflow;

  int nvec = 0;
  int nerr = 0;

  process_delay_line_array #(
    .CHANNELS     (CH),
    .MAX_DELAY    (MAXD),
    .DEFAULT_DELAY(DEFD),
    .EDGE_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_delay(cfg_delay),
    .wire_in  (wire_in),
    .wire_out (wire_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: each queued event is encoded as emit_cycle*2 + level.
  int         mq [CH][$];
  int         m_delay [CH];
  int         m_pend [CH];
  bit         m_pend_v [CH];
  logic [1:0] m_last = '0;
  logic [1:0] exp_out = '0, exp_busy = '0, exp_ovf = '0;
  int         mcyc = 0;
  bit         was_busy;
  int         v;

  function automatic int clamp(int d);
    if (d == 0) return 1;
    if (d > MAXD) return MAXD;
    return d;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        mq[c].delete();
        m_delay[c]  = DEFD;
        m_pend_v[c] = 0;
      end
      m_last = '0; exp_out = '0; exp_busy = '0; exp_ovf = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        was_busy = (mq[c].size() != 0);
        if (mq[c].size() != 0 && (mq[c][0] >> 1) == mcyc) begin
          exp_out[c] = mq[c][0][0];
          void'(mq[c].pop_front());
        end
        if (wire_in[c] != m_last[c]) begin
          m_last[c] = wire_in[c];
`ifdef PDM_INERTIAL_EN
          if (mq[c].size() != 0) void'(mq[c].pop_back());
          else mq[c].push_back(((mcyc + m_delay[c]) << 1) | int'(wire_in[c]));
`else
          if (mq[c].size() < DEPTH) mq[c].push_back(((mcyc + m_delay[c]) << 1) | int'(wire_in[c]));
          else exp_ovf[c] = 1'b1;
`endif
        end
        exp_busy[c] = (mq[c].size() != 0);
        if (cfg_we && int'(cfg_ch) == c) begin
          v = clamp(int'(cfg_delay));
          if (was_busy) begin m_pend_v[c] = 1; m_pend[c] = v; end
          else begin m_delay[c] = v; m_pend_v[c] = 0; end
        end else if (!was_busy && m_pend_v[c]) begin
          m_delay[c] = m_pend[c]; m_pend_v[c] = 0;
        end
      end
    end
    mcyc++;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cfg(input int ch, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_delay = 7'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nvec++;
      if ({wire_out, busy, overflow} !== 6'b0) begin
        nerr++;
        $display("FAIL reset out=%b busy=%b ovf=%b want all 0", wire_out, busy, overflow);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    wire_in[0] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out[0] !== (i >= DEFD) || busy[0] !== (i < DEFD)) begin
        nerr++;
        $display("FAIL latency i=%0d out=%b busy=%b want out=%b busy=%b", i, wire_out[0],
                 busy[0], i >= DEFD, i < DEFD);
      end
    end
    wire_in[0] = 1'b0;
    settle(DEFD + 2);
  endtask

  task automatic test_short_pulse(input int w);
    logic e;
    @(negedge clk);
    wire_in[0] = 1'b1;
    for (int i = 0; i < DEFD + w + 3; i++) begin
      @(negedge clk);
`ifdef PDM_INERTIAL_EN
      e = (w >= DEFD) && (i >= DEFD) && (i < DEFD + w);
`else
      e = (i >= DEFD) && (i < DEFD + w);
`endif
      nvec++;
      if (wire_out[0] !== e) begin
        nerr++;
        $display("FAIL pulse w=%0d i=%0d out=%b want %b", w, i, wire_out[0], e);
      end
      if (i == w - 1) wire_in[0] = 1'b0;
    end
  endtask

  task automatic test_cfg_clamp();
    write_cfg(0, 0);
    wire_in[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out[0] !== (i >= 1)) begin
        nerr++;
        $display("FAIL cfg_zero i=%0d out=%b want %b", i, wire_out[0], i >= 1);
      end
    end
    write_cfg(0, 127);
    wire_in[0] = 1'b0;
    for (int i = 0; i < MAXD + 2; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out[0] !== (i < MAXD)) begin
        nerr++;
        $display("FAIL cfg_max i=%0d out=%b want %b", i, wire_out[0], i < MAXD);
      end
    end
  endtask

  task automatic test_overflow();
    logic eo, ev;
    write_cfg(0, 20);
    wire_in[0] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
`ifdef PDM_INERTIAL_EN
      eo = 1'b0; ev = 1'b0;
`else
      eo = (i == 20) || (i == 22);
      ev = (i >= 4);
`endif
      nvec++;
      if (wire_out[0] !== eo || overflow[0] !== ev) begin
        nerr++;
        $display("FAIL overflow i=%0d out=%b ovf=%b want out=%b ovf=%b", i, wire_out[0],
                 overflow[0], eo, ev);
      end
      if (i < 5) wire_in[0] = ~wire_in[0];
    end
  endtask

  task automatic test_reconfig();
    write_cfg(0, 10);
    wire_in[0] = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out[0] !== (i >= 10 && i < 18)) begin
        nerr++;
        $display("FAIL reconfig i=%0d out=%b want %b", i, wire_out[0], i >= 10 && i < 18);
      end
      if (i == 2) begin cfg_we = 1'b1; cfg_ch = 1'b0; cfg_delay = 7'd5; end
      if (i == 3) cfg_we = 1'b0;
      if (i == 12) wire_in[0] = 1'b0;
    end
  endtask

  task automatic test_race();
    write_cfg(0, 7);
    write_cfg(1, 9);
    wire_in = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out !== {1'(i >= 9), 1'(i >= 7)}) begin
        nerr++;
        $display("FAIL race i=%0d out=%b want %b", i, wire_out, {1'(i >= 9), 1'(i >= 7)});
      end
    end
    wire_in = 2'b00;
    settle(12);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); wire_in[0] = 1'b1;
    @(negedge clk); wire_in[0] = 1'b0;
    @(negedge clk); wire_in[0] = 1'b1;
    @(negedge clk); rst_n = 1'b0; wire_in = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    nvec++;
    if ({wire_out, busy, overflow} !== 6'b0) begin
      nerr++;
      $display("FAIL midreset out=%b busy=%b ovf=%b want all 0", wire_out, busy, overflow);
    end
    for (int i = 0; i < 2 * MAXD; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out !== 2'b00 || busy !== 2'b00) begin
        nerr++;
        $display("FAIL post_reset i=%0d out=%b busy=%b want 00 00", i, wire_out, busy);
      end
    end
  endtask

  // Long random run: the 8-bit timestamp wraps many times under traffic.
  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nvec++;
      if (wire_out !== exp_out || busy !== exp_busy || overflow !== exp_ovf) begin
        nerr++;
        $display("FAIL random i=%0d out=%b busy=%b ovf=%b want out=%b busy=%b ovf=%b", i,
                 wire_out, busy, overflow, exp_out, exp_busy, exp_ovf);
      end
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) wire_in[c] = ~wire_in[c];
      end
      cfg_we    = ($urandom_range(15) == 0);
      cfg_ch    = 1'($urandom_range(1));
      cfg_delay = 7'($urandom_range(127));
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_short_pulse(3);
    test_short_pulse(10);
    test_cfg_clamp();
    test_overflow();
    test_reconfig();
    test_race();
    test_reset_midflight();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
